// File: rtl/nios_system_onchip_mem_tester.sv
// Power-on self-test master for the 16-bit on-chip RAM: writes a pattern over a word range,
// reads it back through the fixed-latency read path and reports pass, error count and first bad address.
module nios_system_onchip_mem_tester #(
    parameter int          ADDR_W       = 13,
    parameter int          DATA_W       = 16,
    parameter int          READ_LATENCY = 1,
    parameter logic [15:0] DEF_SEED     = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic              mode,
    input  logic [15:0]       seed,
    output logic [ADDR_W-1:0] m_address,
    output logic [1:0]        m_byteenable,
    output logic              m_chipselect,
    output logic              m_write,
    output logic [DATA_W-1:0] m_writedata,
    output logic              m_clken,
    input  logic [DATA_W-1:0] m_readdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   LEN_ZERO  = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0]   LEN_ONE   = (ADDR_W+1)'(1);

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    function automatic logic [15:0] seed_init(input logic [15:0] s);
        return (s == 16'h0000) ? DEF_SEED : s;
    endfunction

    function automatic logic [15:0] pattern_word(input logic m, input logic [ADDR_W-1:0] a,
                                                 input logic [15:0] l, input logic [15:0] s);
        return m ? l : (16'(a) ^ s);
    endfunction

    state_t              state_r, state_nxt_s;
    logic [ADDR_W-1:0]   base_r;
    logic [ADDR_W:0]     len_r, rem_r, rem_nxt_s;
    logic                mode_r;
    logic [15:0]         seed_r, lfsr_r, lfsr_nxt_s;
    logic [ADDR_W-1:0]   addr_cnt_r, addr_cnt_nxt_s;
    logic [7:0]          drain_r, drain_nxt_s;
    logic                capture_s, push_s, cs_nxt_s, wr_nxt_s, done_nxt_s, pass_nxt_s;
    logic [ADDR_W-1:0]   addr_nxt_s, push_addr_s, first_nxt_s;
    logic [DATA_W-1:0]   wdata_nxt_s, push_data_s;
    logic [15:0]         err_nxt_s;
    logic                mismatch_s;

    // Expected word/address travel alongside the read so stage READ_LATENCY lines up with readdata.
    logic [DATA_W-1:0]   exp_data_r [0:READ_LATENCY];
    logic [ADDR_W-1:0]   exp_addr_r [0:READ_LATENCY];
    logic [READ_LATENCY:0] exp_vld_r;

    assign m_clken    = 1'b1;
    assign mismatch_s = exp_vld_r[READ_LATENCY] && (m_readdata != exp_data_r[READ_LATENCY]);

    // Next-state and next-output logic; outputs are registered from these values.
    always_comb begin
        state_nxt_s    = state_r;
        addr_cnt_nxt_s = addr_cnt_r;
        lfsr_nxt_s     = lfsr_r;
        rem_nxt_s      = rem_r;
        drain_nxt_s    = drain_r;
        cs_nxt_s       = 1'b0;
        wr_nxt_s       = 1'b0;
        addr_nxt_s     = ADDR_ZERO;
        wdata_nxt_s    = 16'h0000;
        done_nxt_s     = 1'b0;
        pass_nxt_s     = pass;
        capture_s      = 1'b0;
        push_s         = 1'b0;
        push_addr_s    = ADDR_ZERO;
        push_data_s    = 16'h0000;
        if (abort) begin
            state_nxt_s = ST_IDLE;
            pass_nxt_s  = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        capture_s  = 1'b1;
                        pass_nxt_s = 1'b0;
                        if (length == LEN_ZERO) begin
                            state_nxt_s = ST_DONE;
                            done_nxt_s  = 1'b1;
                            pass_nxt_s  = 1'b1;
                        end else begin
                            state_nxt_s    = ST_WRITE;
                            cs_nxt_s       = 1'b1;
                            wr_nxt_s       = 1'b1;
                            addr_nxt_s     = base_addr;
                            wdata_nxt_s    = pattern_word(mode, base_addr, seed_init(seed), seed);
                            addr_cnt_nxt_s = base_addr + ADDR_ONE;
                            lfsr_nxt_s     = lfsr_step(seed_init(seed));
                            rem_nxt_s      = length - LEN_ONE;
                        end
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    if (rem_r != LEN_ZERO) begin
                        cs_nxt_s       = 1'b1;
                        wr_nxt_s       = 1'b1;
                        addr_nxt_s     = addr_cnt_r;
                        wdata_nxt_s    = pattern_word(mode_r, addr_cnt_r, lfsr_r, seed_r);
                        addr_cnt_nxt_s = addr_cnt_r + ADDR_ONE;
                        lfsr_nxt_s     = lfsr_step(lfsr_r);
                        rem_nxt_s      = rem_r - LEN_ONE;
                    end else begin
                        // Readback regenerates the same sequence from the captured base and seed.
                        state_nxt_s    = ST_READ;
                        cs_nxt_s       = 1'b1;
                        addr_nxt_s     = base_r;
                        push_s         = 1'b1;
                        push_addr_s    = base_r;
                        push_data_s    = pattern_word(mode_r, base_r, seed_init(seed_r), seed_r);
                        addr_cnt_nxt_s = base_r + ADDR_ONE;
                        lfsr_nxt_s     = lfsr_step(seed_init(seed_r));
                        rem_nxt_s      = len_r - LEN_ONE;
                    end
                end
                ST_READ: begin
                    if (rem_r != LEN_ZERO) begin
                        cs_nxt_s       = 1'b1;
                        addr_nxt_s     = addr_cnt_r;
                        push_s         = 1'b1;
                        push_addr_s    = addr_cnt_r;
                        push_data_s    = pattern_word(mode_r, addr_cnt_r, lfsr_r, seed_r);
                        addr_cnt_nxt_s = addr_cnt_r + ADDR_ONE;
                        lfsr_nxt_s     = lfsr_step(lfsr_r);
                        rem_nxt_s      = rem_r - LEN_ONE;
                    end else begin
                        state_nxt_s = ST_DRAIN;
                        drain_nxt_s = 8'(READ_LATENCY - 1);
                    end
                end
                ST_DRAIN: begin
                    if (drain_r == 8'd0) begin
                        state_nxt_s = ST_DONE;
                        done_nxt_s  = 1'b1;
                        pass_nxt_s  = (err_count == 16'h0000) && !mismatch_s;
                    end else begin
                        drain_nxt_s = drain_r - 8'd1;
                    end
                end
                ST_DONE: begin
                    state_nxt_s = ST_IDLE;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // Saturating error counter and first-failure capture; both clear when a test is accepted.
    always_comb begin
        err_nxt_s   = err_count;
        first_nxt_s = first_err_addr;
        if (capture_s) begin
            err_nxt_s   = 16'h0000;
            first_nxt_s = ADDR_ZERO;
        end else if (mismatch_s) begin
            if (err_count != 16'hFFFF) begin
                err_nxt_s = err_count + 16'h0001;
            end else begin
                err_nxt_s = err_count;
            end
            if (err_count == 16'h0000) begin
                first_nxt_s = exp_addr_r[READ_LATENCY];
            end else begin
                first_nxt_s = first_err_addr;
            end
        end else begin
            err_nxt_s   = err_count;
            first_nxt_s = first_err_addr;
        end
    end

    // State, counters, captured test parameters and registered bus/status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            base_r         <= ADDR_ZERO;
            len_r          <= LEN_ZERO;
            mode_r         <= 1'b0;
            seed_r         <= 16'h0000;
            lfsr_r         <= 16'h0000;
            addr_cnt_r     <= ADDR_ZERO;
            rem_r          <= LEN_ZERO;
            drain_r        <= 8'd0;
            m_address      <= ADDR_ZERO;
            m_byteenable   <= 2'b00;
            m_chipselect   <= 1'b0;
            m_write        <= 1'b0;
            m_writedata    <= 16'h0000;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= 16'h0000;
            first_err_addr <= ADDR_ZERO;
        end else begin
            state_r        <= state_nxt_s;
            lfsr_r         <= lfsr_nxt_s;
            addr_cnt_r     <= addr_cnt_nxt_s;
            rem_r          <= rem_nxt_s;
            drain_r        <= drain_nxt_s;
            m_address      <= addr_nxt_s;
            m_byteenable   <= cs_nxt_s ? 2'b11 : 2'b00;
            m_chipselect   <= cs_nxt_s;
            m_write        <= wr_nxt_s;
            m_writedata    <= wdata_nxt_s;
            busy           <= (state_nxt_s == ST_WRITE) || (state_nxt_s == ST_READ) ||
                              (state_nxt_s == ST_DRAIN);
            done           <= done_nxt_s;
            pass           <= pass_nxt_s;
            err_count      <= err_nxt_s;
            first_err_addr <= first_nxt_s;
            if (capture_s) begin
                base_r <= base_addr;
                len_r  <= length;
                mode_r <= mode;
                seed_r <= seed;
            end
        end
    end

    // Expected-value pipeline; an abort discards whatever reads are still in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            exp_vld_r <= {(READ_LATENCY+1){1'b0}};
            for (int k = 0; k <= READ_LATENCY; k++) begin
                exp_data_r[k] <= 16'h0000;
                exp_addr_r[k] <= ADDR_ZERO;
            end
        end else begin
            exp_vld_r     <= abort ? {(READ_LATENCY+1){1'b0}} : {exp_vld_r[READ_LATENCY-1:0], push_s};
            exp_data_r[0] <= push_data_s;
            exp_addr_r[0] <= push_addr_s;
            for (int k = 1; k <= READ_LATENCY; k++) begin
                exp_data_r[k] <= exp_data_r[k-1];
                exp_addr_r[k] <= exp_addr_r[k-1];
            end
        end
    end

endmodule
